mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 75 +++++++
 tb/tb_mem_arbiter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master round-robin arbiter onto one picorv32-native memory port with grant timeout.
module mem_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        res,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m0_addr,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_wdata,
  input  logic [31:0] m1_addr,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic        s_instr,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_wdata,
  output logic [31:0] s_addr,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic        timeout_err
);
  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  state_t      r_state, w_next;
  logic        r_last;
  logic [7:0]  r_cnt;
  logic        w_busy, w_g0, w_g1, w_to, w_done;
  always_ff @(posedge clk) begin
    if (res) r_state <= IDLE;
    else     r_state <= w_next;
  end
  // On a tie the master that did not win last time is granted.
  always_comb begin
    w_busy = r_state != IDLE;
    w_to   = w_busy & ~s_ready & (r_cnt == TO_LAST);
    w_done = w_busy & (s_ready | w_to);
    w_next = r_state == IDLE
           ? (m0_valid & m1_valid ? (r_last ? BUSY0 : BUSY1)
             : m0_valid ? BUSY0 : m1_valid ? BUSY1 : IDLE)
           : (w_done ? IDLE : r_state);
  end
  always_ff @(posedge clk) begin
    if (res) begin
      r_last <= 1'b1;
      r_cnt  <= 8'd0;
    end else if (r_state == IDLE && w_next != IDLE) begin
      r_last <= w_next == BUSY1;
      r_cnt  <= 8'd0;
    end else if (w_busy) begin
      r_cnt  <= r_cnt + 8'd1;
    end
  end
  always_comb begin
    w_g0        = r_state == BUSY0;
    w_g1        = r_state == BUSY1;
    s_valid     = w_busy;
    s_instr     = w_g1 ? m1_instr : w_g0 ? m0_instr : 1'b0;
    s_wstrb     = w_g1 ? m1_wstrb : w_g0 ? m0_wstrb : 4'h0;
    s_wdata     = w_g1 ? m1_wdata : w_g0 ? m0_wdata : 32'h0;
    s_addr      = w_g1 ? m1_addr  : w_g0 ? m0_addr  : 32'h0;
    m0_ready    = w_g0 & w_done;
    m1_ready    = w_g1 & w_done;
    m0_rdata    = w_g0 & s_ready ? s_rdata : 32'h0;
    m1_rdata    = w_g1 & s_ready ? s_rdata : 32'h0;
    timeout_err = w_to;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenario checks for mem_arbiter built with TIMEOUT=4.
module tb_mem_arbiter;
  logic        clk = 0, res = 0;
  logic        m0_valid = 0, m0_instr = 0, m1_valid = 0, m1_instr = 0;
  logic [3:0]  m0_wstrb = 0, m1_wstrb = 0;
  logic [31:0] m0_wdata = 0, m0_addr = 0, m1_wdata = 0, m1_addr = 0;
  logic        m0_ready, m1_ready, s_valid, s_instr, timeout_err;
  logic [31:0] m0_rdata, m1_rdata, s_wdata, s_addr;
  logic [3:0]  s_wstrb;
  logic        s_ready = 0;
  logic [31:0] s_rdata = 0;
  int n_cmp = 0, n_bad = 0;

  mem_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .res(res),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_wstrb(m0_wstrb), .m0_wdata(m0_wdata), .m0_addr(m0_addr),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_wstrb(m1_wstrb), .m1_wdata(m1_wdata), .m1_addr(m1_addr),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_instr(s_instr), .s_wstrb(s_wstrb), .s_wdata(s_wdata), .s_addr(s_addr),
    .s_ready(s_ready), .s_rdata(s_rdata), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    res = 1; m0_valid = 1; m1_valid = 1; m0_addr = 32'h100; m1_addr = 32'h200;
    tick; tick;
    m0_valid = 0; m1_valid = 0;
    #1;
    n_cmp++; if (s_valid !== 1'b0) begin n_bad++; $display("FAIL reset_s_valid got %b exp 0", s_valid); end
    n_cmp++; if ({m0_ready, m1_ready, timeout_err} !== 3'b000) begin n_bad++; $display("FAIL reset_ready got %b exp 000", {m0_ready, m1_ready, timeout_err}); end
    n_cmp++; if ({m0_rdata, m1_rdata} !== 64'h0) begin n_bad++; $display("FAIL reset_rdata got %h exp 0", {m0_rdata, m1_rdata}); end
    res = 0;
    tick;
    n_cmp++; if (s_valid !== 1'b0) begin n_bad++; $display("FAIL post_reset_s_valid got %b exp 0", s_valid); end
  endtask

  task automatic test_single_read;
    m0_valid = 1; m0_addr = 32'h10; m0_wstrb = 4'h0;
    tick;
    n_cmp++; if ({s_valid, s_addr} !== {1'b1, 32'h10}) begin n_bad++; $display("FAIL read_req got %b/%h exp 1/00000010", s_valid, s_addr); end
    n_cmp++; if (m0_ready !== 1'b0) begin n_bad++; $display("FAIL read_early_ready got %b exp 0", m0_ready); end
    tick;
    s_ready = 1; s_rdata = 32'hDEADBEEF; #1;
    n_cmp++; if ({m0_ready, m0_rdata} !== {1'b1, 32'hDEADBEEF}) begin n_bad++; $display("FAIL read_resp got %b/%h exp 1/deadbeef", m0_ready, m0_rdata); end
    n_cmp++; if ({m1_ready, m1_rdata} !== {1'b0, 32'h0}) begin n_bad++; $display("FAIL read_other got %b/%h exp 0/0", m1_ready, m1_rdata); end
    tick;
    s_ready = 0; m0_valid = 0; #1;
    n_cmp++; if ({s_valid, m0_ready} !== 2'b00) begin n_bad++; $display("FAIL read_after got %b exp 00", {s_valid, m0_ready}); end
    tick;
  endtask

  task automatic test_tie;
    logic [3:0] order;
    order = 4'b1010;
    res = 1; tick; res = 0;
    m0_valid = 1; m1_valid = 1; m0_addr = 32'h100; m1_addr = 32'h200;
    for (int g = 0; g < 4; g++) begin
      tick;
      n_cmp++; if ({s_valid, s_addr} !== {1'b1, order[g] ? 32'h200 : 32'h100}) begin n_bad++; $display("FAIL tie_grant%0d got %b/%h exp 1/%h", g, s_valid, s_addr, order[g] ? 32'h200 : 32'h100); end
      s_ready = 1; s_rdata = 32'hC0DE0000 + g; #1;
      n_cmp++; if ({m0_ready, m1_ready} !== (order[g] ? 2'b01 : 2'b10)) begin n_bad++; $display("FAIL tie_ready%0d got %b exp %b", g, {m0_ready, m1_ready}, order[g] ? 2'b01 : 2'b10); end
      tick;
      s_ready = 0; #1;
      n_cmp++; if (s_valid !== 1'b0) begin n_bad++; $display("FAIL tie_gap%0d got %b exp 0", g, s_valid); end
    end
    m0_valid = 0; m1_valid = 0;
    tick;
  endtask

  task automatic test_write;
    m1_valid = 1; m1_instr = 0; m1_wstrb = 4'b0101; m1_wdata = 32'h11223344; m1_addr = 32'h200;
    m0_wstrb = 4'b1111; m0_wdata = 32'hFFFFFFFF; m0_addr = 32'h300;
    tick;
    n_cmp++; if ({s_valid, s_wstrb, s_wdata, s_addr} !== {1'b1, 4'b0101, 32'h11223344, 32'h200}) begin n_bad++; $display("FAIL write_pass got %b/%b/%h/%h exp 1/0101/11223344/00000200", s_valid, s_wstrb, s_wdata, s_addr); end
    s_ready = 1; s_rdata = 32'h55; #1;
    n_cmp++; if ({m1_ready, m1_rdata, m0_ready, m0_rdata} !== {1'b1, 32'h55, 1'b0, 32'h0}) begin n_bad++; $display("FAIL write_resp got %b/%h/%b/%h exp 1/55/0/0", m1_ready, m1_rdata, m0_ready, m0_rdata); end
    tick;
    s_ready = 0; m1_valid = 0; m0_wstrb = 0;
    tick;
  endtask

  task automatic test_timeout;
    m0_valid = 1; m0_addr = 32'h40; s_rdata = 32'hAAAA5555;
    for (int c = 1; c <= 3; c++) begin
      tick;
      n_cmp++; if ({s_valid, m0_ready, timeout_err} !== 3'b100) begin n_bad++; $display("FAIL to_wait%0d got %b exp 100", c, {s_valid, m0_ready, timeout_err}); end
    end
    tick;
    n_cmp++; if ({m0_ready, m0_rdata, timeout_err, m1_ready} !== {1'b1, 32'h0, 1'b1, 1'b0}) begin n_bad++; $display("FAIL to_abort got %b/%h/%b/%b exp 1/0/1/0", m0_ready, m0_rdata, timeout_err, m1_ready); end
    m0_valid = 0;
    tick;
    n_cmp++; if ({s_valid, m0_ready, timeout_err} !== 3'b000) begin n_bad++; $display("FAIL to_idle got %b exp 000", {s_valid, m0_ready, timeout_err}); end
  endtask

  task automatic test_reset_mid;
    m0_valid = 1; m0_addr = 32'h100; m1_addr = 32'h200;
    tick; tick;
    n_cmp++; if (s_valid !== 1'b1) begin n_bad++; $display("FAIL rst_mid_busy got %b exp 1", s_valid); end
    res = 1; m0_valid = 0; #1;
    n_cmp++; if (m0_ready !== 1'b0) begin n_bad++; $display("FAIL rst_mid_ready got %b exp 0", m0_ready); end
    tick;
    res = 0; #1;
    n_cmp++; if ({s_valid, m0_ready, m1_ready} !== 3'b000) begin n_bad++; $display("FAIL rst_mid_after got %b exp 000", {s_valid, m0_ready, m1_ready}); end
    m0_valid = 1; m1_valid = 1;
    tick;
    n_cmp++; if (s_addr !== 32'h100) begin n_bad++; $display("FAIL rst_mid_tie got %h exp 00000100", s_addr); end
    s_ready = 1; tick; s_ready = 0; m0_valid = 0; m1_valid = 0;
    tick;
  endtask

  task automatic test_stray_ready;
    s_ready = 1; s_rdata = 32'h12345678; #1;
    n_cmp++; if ({m0_ready, m1_ready, m0_rdata, m1_rdata} !== {2'b00, 64'h0}) begin n_bad++; $display("FAIL stray_resp got %b%b/%h/%h exp 00/0/0", m0_ready, m1_ready, m0_rdata, m1_rdata); end
    tick;
    n_cmp++; if ({s_valid, m0_ready, m1_ready} !== 3'b000) begin n_bad++; $display("FAIL stray_state got %b exp 000", {s_valid, m0_ready, m1_ready}); end
    s_ready = 0;
    tick;
  endtask

  initial begin
    test_reset;
    test_single_read;
    test_tie;
    test_write;
    test_timeout;
    test_reset_mid;
    test_stray_ready;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired got running exp finished");
    $fatal(1, "watchdog");
  end
endmodule
